// File: rtl/frame_mode_sequencer.sv
// Frame-boundary mode controller: debounces the DIP mode switches, commits a new mode only
// between image-buffer frames, gates frame starts while it settles, and supervises frames.
module frame_mode_sequencer #(
  parameter int STABLE_CYCLES  = 1000,
  parameter int SETTLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk_10M,
  input  logic       reset,
  input  logic [2:0] dip_async,
  input  logic       bg_start,
  input  logic       bg_start_ack,
  input  logic       bg_done,
  output logic       start_enable,
  output logic       mode_scroll,
  output logic       mode_vga_enable,
  output logic       mode_filter,
  output logic       mode_pending,
  output logic       frame_active,
  output logic [7:0] frame_count,
  output logic [7:0] timeout_count,
  output logic       timeout_flag
);

  localparam int SW = $clog2(STABLE_CYCLES + 1);
  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SW-1:0] STAB_LAST   = SW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYCLES - 1);
  localparam logic [WW-1:0] WD_LAST     = WW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FRAME = 2'd1,
    ST_APPLY = 2'd2
  } state_t;

  state_t        r_state;
  logic [2:0]    r_sync1;
  logic [2:0]    r_sync2;
  logic [2:0]    r_dip_db;
  logic [SW-1:0] r_stab_cnt;
  logic [CW-1:0] r_settle;
  logic [WW-1:0] r_wd;
  logic          r_fs_prev;
  logic          r_fd_prev;

  logic       w_start_lvl;
  logic       w_fs;
  logic       w_fd;
  logic [2:0] w_mode;
  logic       w_wd_expired;
  logic       w_frame_end;
  logic       w_enter_apply;

  assign w_start_lvl  = bg_start & bg_start_ack;
  assign w_fs         = w_start_lvl & ~r_fs_prev;
  assign w_fd         = bg_done & ~r_fd_prev;
  assign w_mode       = {mode_filter, mode_vga_enable, mode_scroll};
  assign w_wd_expired = (r_wd == WD_LAST);
  assign w_frame_end  = (r_state == ST_FRAME) && (w_fd || w_wd_expired);
  // fs beats a pending commit in IDLE; a frame end with a pending change goes straight to APPLY
  assign w_enter_apply = mode_pending && (((r_state == ST_IDLE) && !w_fs) || w_frame_end);

  // DIP synchronizer and stability counter; the counter clears on the edge the synced value moves
  always_ff @(posedge clk_10M) begin
    if (reset) begin
      r_sync1    <= 3'b000;
      r_sync2    <= 3'b000;
      r_dip_db   <= 3'b000;
      r_stab_cnt <= '0;
    end else begin
      r_sync1 <= dip_async;
      r_sync2 <= r_sync1;
      if (r_sync1 != r_sync2) begin
        r_stab_cnt <= '0;
      end else if (r_stab_cnt == STAB_LAST) begin
        r_dip_db <= r_sync2;
      end else begin
        r_stab_cnt <= r_stab_cnt + SW'(1);
      end
    end
  end

  // Frame/mode FSM with all status outputs registered
  always_ff @(posedge clk_10M) begin
    if (reset) begin
      r_state         <= ST_IDLE;
      r_settle        <= '0;
      r_wd            <= '0;
      r_fs_prev       <= 1'b0;
      r_fd_prev       <= 1'b0;
      mode_scroll     <= 1'b0;
      mode_vga_enable <= 1'b0;
      mode_filter     <= 1'b0;
      mode_pending    <= 1'b0;
      start_enable    <= 1'b1;
      frame_active    <= 1'b0;
      frame_count     <= 8'd0;
      timeout_count   <= 8'd0;
      timeout_flag    <= 1'b0;
    end else begin
      r_fs_prev    <= w_start_lvl;
      r_fd_prev    <= bg_done;
      mode_pending <= (r_dip_db != w_mode);
      case (r_state)
        ST_IDLE: begin
          if (w_fs) begin
            r_state      <= ST_FRAME;
            frame_active <= 1'b1;
            r_wd         <= '0;
            timeout_flag <= 1'b0;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_FRAME: begin
          if (w_fd) begin
            frame_count  <= frame_count + 8'd1;
            frame_active <= 1'b0;
            r_state      <= ST_IDLE;
          end else if (w_wd_expired) begin
            timeout_flag <= 1'b1;
            if (timeout_count != 8'hFF) begin
              timeout_count <= timeout_count + 8'd1;
            end
            frame_active <= 1'b0;
            r_state      <= ST_IDLE;
          end else begin
            r_wd <= r_wd + WW'(1);
          end
        end
        ST_APPLY: begin
          if (r_settle == '0) begin
            r_state      <= ST_IDLE;
            start_enable <= 1'b1;
          end else begin
            r_settle <= r_settle - CW'(1);
          end
        end
        default: begin
          r_state      <= ST_IDLE;
          start_enable <= 1'b1;
          frame_active <= 1'b0;
        end
      endcase
      // APPLY entry overrides the IDLE fallback chosen above
      if (w_enter_apply) begin
        r_state                                     <= ST_APPLY;
        {mode_filter, mode_vga_enable, mode_scroll} <= r_dip_db;
        r_settle                                    <= SETTLE_LOAD;
        start_enable                                <= 1'b0;
      end
    end
  end

endmodule
